// File: rtl/rsa_host_pkg.sv
// Shared constants for the RSA host interface: opcodes, FSM state encoding
// and command-word field positions.
package rsa_host_pkg;

  localparam logic [3:0] OP_COMPUTE_EXP  = 4'd0;
  localparam logic [3:0] OP_COMPUTE_MONT = 4'd1;
  localparam logic [3:0] OP_READ_MOD     = 4'd2;
  localparam logic [3:0] OP_READ_RSQ     = 4'd3;
  localparam logic [3:0] OP_READ_EXP     = 4'd4;
  localparam logic [3:0] OP_WRITE        = 4'd5;
  localparam logic [3:0] OP_READ_SLOT    = 4'd6;

  localparam int OP_LSB   = 0;
  localparam int SLOT_LSB = 4;
  localparam int CORE_LSB = 8;
  localparam int FIELD_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX      = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_TX      = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/rsa_slot_bank.sv
// Operand slot storage: one write port, all slots visible on a flat bus.
module rsa_slot_bank #(
  parameter  int DATA_W    = 1024,
  parameter  int NUM_SLOTS = 4,
  localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          we,
  input  logic [IDX_W-1:0]              idx,
  input  logic [DATA_W-1:0]             wdata,
  output logic [NUM_SLOTS*DATA_W-1:0]   rdata
);

  // Slot registers, cleared by reset and written one slot at a time.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata <= '0;
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (we && (idx == IDX_W'(s))) begin
          rdata[s*DATA_W +: DATA_W] <= wdata;
        end
      end
    end
  end

endmodule

// File: rtl/rsa_host_if.sv
// Host command decoder and sequencer for a bank of Montgomery/RSA cores:
// loads operand slots, starts one core, and returns its latched result.
module rsa_host_if
  import rsa_host_pkg::*;
#(
  parameter int DATA_W    = 1024,
  parameter int NUM_SLOTS = 4,
  parameter int NUM_CORES = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [31:0]                   arm_to_fpga_cmd,
  input  logic                          arm_to_fpga_cmd_valid,
  output logic                          fpga_to_arm_done,
  input  logic                          fpga_to_arm_done_read,
  input  logic                          arm_to_fpga_data_valid,
  output logic                          arm_to_fpga_data_ready,
  input  logic [DATA_W-1:0]             arm_to_fpga_data,
  output logic                          fpga_to_arm_data_valid,
  input  logic                          fpga_to_arm_data_ready,
  output logic [DATA_W-1:0]             fpga_to_arm_data,
  output logic [NUM_CORES-1:0]          core_start,
  output logic                          core_mode,
  input  logic [NUM_CORES-1:0]          core_done,
  input  logic [NUM_CORES*DATA_W-1:0]   core_result,
  output logic [NUM_SLOTS*DATA_W-1:0]   slot_data,
  output logic                          cmd_error,
  output logic [3:0]                    leds
);

  localparam int         SLOT_IW    = $clog2(NUM_SLOTS);
  localparam int         CORE_IW    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int         CORE_N     = 1 << CORE_IW;
  localparam logic [4:0] SLOT_LIMIT = 5'(NUM_SLOTS);
  localparam logic [4:0] CORE_LIMIT = 5'(NUM_CORES);

  state_t                 state;
  state_t                 next_state;
  state_t                 dec_state;
  logic [FIELD_W-1:0]     op;
  logic [FIELD_W-1:0]     slot_f;
  logic [FIELD_W-1:0]     core_f;
  logic [FIELD_W-1:0]     dec_slot;
  logic                   dec_err;
  logic                   accept;
  logic                   slot_we;
  logic                   take_result;
  logic [SLOT_IW-1:0]     tgt_slot;
  logic [CORE_IW-1:0]     core_sel;
  logic [CORE_N-1:0]      done_ext;
  logic [DATA_W-1:0]      result;
  logic [DATA_W-1:0]      core_res [CORE_N];
  logic                   unused_cmd_bits;

  assign op              = arm_to_fpga_cmd[OP_LSB   +: FIELD_W];
  assign slot_f          = arm_to_fpga_cmd[SLOT_LSB +: FIELD_W];
  assign core_f          = arm_to_fpga_cmd[CORE_LSB +: FIELD_W];
  assign unused_cmd_bits = ^arm_to_fpga_cmd[31:12];
  assign done_ext        = CORE_N'(core_done);

  // Pad the core bank to a power of two so core_sel indexes it exactly.
  for (genvar k = 0; k < CORE_N; k++) begin : g_res
    if (k < NUM_CORES) begin : g_on
      assign core_res[k] = core_result[k*DATA_W +: DATA_W];
    end else begin : g_off
      assign core_res[k] = '0;
    end
  end

  // Command decode: target state, target slot and validity of the word.
  always_comb begin
    dec_state = ST_DONE;
    dec_slot  = 4'd0;
    dec_err   = 1'b0;
    case (op)
      OP_COMPUTE_EXP, OP_COMPUTE_MONT: begin
        dec_state = ST_COMPUTE;
        dec_err   = ({1'b0, core_f} >= CORE_LIMIT);
      end
      OP_READ_MOD: begin
        dec_state = ST_RX;
        dec_slot  = 4'd0;
        dec_err   = ({1'b0, dec_slot} >= SLOT_LIMIT);
      end
      OP_READ_RSQ: begin
        dec_state = ST_RX;
        dec_slot  = 4'd1;
        dec_err   = ({1'b0, dec_slot} >= SLOT_LIMIT);
      end
      OP_READ_EXP: begin
        dec_state = ST_RX;
        dec_slot  = 4'd2;
        dec_err   = ({1'b0, dec_slot} >= SLOT_LIMIT);
      end
      OP_WRITE: begin
        dec_state = ST_TX;
      end
      OP_READ_SLOT: begin
        dec_state = ST_RX;
        dec_slot  = slot_f;
        dec_err   = ({1'b0, dec_slot} >= SLOT_LIMIT);
      end
      default: begin
        dec_err = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and per-state transfer strobes.
  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    slot_we     = 1'b0;
    take_result = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arm_to_fpga_cmd_valid) begin
          accept     = 1'b1;
          next_state = dec_err ? ST_DONE : dec_state;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_RX: begin
        if (arm_to_fpga_data_valid) begin
          slot_we    = 1'b1;
          next_state = ST_DONE;
        end else begin
          next_state = ST_RX;
        end
      end
      ST_COMPUTE: begin
        if (done_ext[core_sel]) begin
          take_result = 1'b1;
          next_state  = ST_DONE;
        end else begin
          next_state = ST_COMPUTE;
        end
      end
      ST_TX: begin
        if (fpga_to_arm_data_ready) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_TX;
        end
      end
      ST_DONE: begin
        if (fpga_to_arm_done_read) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_DONE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Command context, start pulse and result register; mode only changes on compute.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tgt_slot   <= '0;
      core_sel   <= '0;
      core_mode  <= 1'b0;
      core_start <= '0;
      cmd_error  <= 1'b0;
      result     <= '0;
    end else begin
      core_start <= '0;
      if (accept) begin
        cmd_error <= dec_err;
        tgt_slot  <= dec_slot[SLOT_IW-1:0];
        if (!dec_err && (dec_state == ST_COMPUTE)) begin
          core_sel   <= core_f[CORE_IW-1:0];
          core_mode  <= op[0];
          core_start <= NUM_CORES'(1) << core_f;
        end
      end
      if (take_result) begin
        result <= core_res[core_sel];
      end
    end
  end

  rsa_slot_bank #(
    .DATA_W    (DATA_W),
    .NUM_SLOTS (NUM_SLOTS)
  ) u_slots (
    .clk    (clk),
    .resetn (resetn),
    .we     (slot_we),
    .idx    (tgt_slot),
    .wdata  (arm_to_fpga_data),
    .rdata  (slot_data)
  );

  assign arm_to_fpga_data_ready = (state == ST_RX);
  assign fpga_to_arm_data_valid = (state == ST_TX);
  assign fpga_to_arm_done       = (state == ST_DONE);
  assign fpga_to_arm_data       = result;
  assign leds                   = {cmd_error, state};

endmodule

// File: tb/tb_rsa_host_if.sv
// Self-checking bench for rsa_host_if: directed vector table, random commands
// against a command-level reference model, and a mid-transfer reset sequence.
module tb_rsa_host_if;

  localparam int DW = 1024;
  localparam int NS = 4;
  localparam int NC = 2;
  localparam logic [2:0] S_IDLE = 3'd0, S_RX = 3'd1, S_COMP = 3'd2, S_TX = 3'd3, S_DONE = 3'd4;

  logic            clk = 1'b0;
  logic            resetn;
  logic [31:0]     arm_to_fpga_cmd;
  logic            arm_to_fpga_cmd_valid;
  logic            fpga_to_arm_done;
  logic            fpga_to_arm_done_read;
  logic            arm_to_fpga_data_valid;
  logic            arm_to_fpga_data_ready;
  logic [DW-1:0]   arm_to_fpga_data;
  logic            fpga_to_arm_data_valid;
  logic            fpga_to_arm_data_ready;
  logic [DW-1:0]   fpga_to_arm_data;
  logic [NC-1:0]   core_start;
  logic            core_mode;
  logic [NC-1:0]   core_done;
  logic [NC*DW-1:0] core_result;
  logic [NS*DW-1:0] slot_data;
  logic            cmd_error;
  logic [3:0]      leds;

  always #5 clk = ~clk;

  rsa_host_if #(.DATA_W(DW), .NUM_SLOTS(NS), .NUM_CORES(NC)) dut (
    .clk(clk), .resetn(resetn),
    .arm_to_fpga_cmd(arm_to_fpga_cmd), .arm_to_fpga_cmd_valid(arm_to_fpga_cmd_valid),
    .fpga_to_arm_done(fpga_to_arm_done), .fpga_to_arm_done_read(fpga_to_arm_done_read),
    .arm_to_fpga_data_valid(arm_to_fpga_data_valid), .arm_to_fpga_data_ready(arm_to_fpga_data_ready),
    .arm_to_fpga_data(arm_to_fpga_data),
    .fpga_to_arm_data_valid(fpga_to_arm_data_valid), .fpga_to_arm_data_ready(fpga_to_arm_data_ready),
    .fpga_to_arm_data(fpga_to_arm_data),
    .core_start(core_start), .core_mode(core_mode), .core_done(core_done), .core_result(core_result),
    .slot_data(slot_data), .cmd_error(cmd_error), .leds(leds)
  );

  typedef struct {
    logic [3:0]    op;
    logic [3:0]    slot;
    logic [3:0]    core;
    int            delay;
    bit            decoy;
    int            hold;
    bit            exp_err;
    logic [2:0]    exp_st;
    logic [DW-1:0] data;
    logic [DW-1:0] res;
  } vec_t;

  vec_t          tbl[$];
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] m_slot [NS];
  logic [DW-1:0] m_result;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (low 256 bits)", name, act[255:0], exp[255:0]);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input logic [3:0] slot, input logic [3:0] core,
                              input int delay, input bit decoy, input int hold, input bit exp_err,
                              input logic [2:0] exp_st, input logic [DW-1:0] data, input logic [DW-1:0] res);
    vec_t v;
    v.op = op; v.slot = slot; v.core = core; v.delay = delay; v.decoy = decoy; v.hold = hold;
    v.exp_err = exp_err; v.exp_st = exp_st; v.data = data; v.res = res;
    return v;
  endfunction

  // Reference rules: what a command word should do, from its fields alone.
  function automatic bit m_err(input logic [3:0] op, input logic [3:0] slot, input logic [3:0] core);
    if (op == 4'd0 || op == 4'd1) return int'(core) >= NC;
    if (op >= 4'd2 && op <= 4'd5) return 1'b0;
    if (op == 4'd6) return int'(slot) >= NS;
    return 1'b1;
  endfunction

  function automatic logic [2:0] m_state(input logic [3:0] op, input logic [3:0] slot, input logic [3:0] core);
    if (m_err(op, slot, core)) return S_DONE;
    if (op <= 4'd1) return S_COMP;
    if (op == 4'd5) return S_TX;
    return S_RX;
  endfunction

  task automatic check_slots(input string tag);
    for (int s = 0; s < NS; s++) chk($sformatf("%s_slot%0d", tag, s), slot_data[s*DW +: DW], m_slot[s]);
  endtask

  task automatic run_cmd(input vec_t v);
    int tgt;
    int other;
    arm_to_fpga_cmd       = {20'($urandom), v.core, v.slot, v.op};
    arm_to_fpga_cmd_valid = 1'b1;
    tick;
    arm_to_fpga_cmd_valid = 1'b0;
    chk("state_n1", leds[2:0], v.exp_st);
    chk("cmd_error", cmd_error, v.exp_err);
    chk("leds_err", leds[3], v.exp_err);
    if (v.exp_err) begin
      chk("err_done_n1", fpga_to_arm_done, 1'b1);
      chk("err_no_start", core_start, '0);
    end else begin
      chk("done_low_n1", fpga_to_arm_done, 1'b0);
      case (v.exp_st)
        S_RX: begin
          tgt = (v.op == 4'd6) ? int'(v.slot) : int'(v.op) - 2;
          chk("rx_ready", arm_to_fpga_data_ready, 1'b1);
          repeat (v.delay) tick;
          chk("rx_wait_state", leds[2:0], S_RX);
          arm_to_fpga_data       = v.data;
          arm_to_fpga_data_valid = 1'b1;
          tick;
          arm_to_fpga_data_valid = 1'b0;
          m_slot[tgt] = v.data;
        end
        S_COMP: begin
          chk("start_onehot", core_start, 1 << v.core);
          chk("mode", core_mode, v.op[0]);
          for (int i = 0; i < v.delay; i++) begin
            if (i == 0 && v.decoy) begin
              other = (v.core == 4'd0) ? 1 : 0;
              core_result[other*DW +: DW] = ~v.res;
              core_done[other] = 1'b1;
            end
            arm_to_fpga_cmd       = $urandom;
            arm_to_fpga_cmd_valid = 1'b1;
            tick;
            core_done = '0;
            if (i == 0) chk("start_once", core_start, '0);
            chk("compute_wait", leds[2:0], S_COMP);
            chk("mode_stable", core_mode, v.op[0]);
          end
          arm_to_fpga_cmd_valid = 1'b0;
          core_result[int'(v.core)*DW +: DW] = v.res;
          core_done[v.core] = 1'b1;
          tick;
          core_done = '0;
          m_result = v.res;
        end
        S_TX: begin
          chk("tx_valid", fpga_to_arm_data_valid, 1'b1);
          chk("tx_data", fpga_to_arm_data, m_result);
          repeat (v.delay) tick;
          chk("tx_wait_state", leds[2:0], S_TX);
          fpga_to_arm_data_ready = 1'b1;
          tick;
          fpga_to_arm_data_ready = 1'b0;
        end
        default: ;
      endcase
      chk("done_after_xfer", fpga_to_arm_done, 1'b1);
    end
    chk("state_done", leds[2:0], S_DONE);
    repeat (v.hold) tick;
    chk("done_held", fpga_to_arm_done, 1'b1);
    fpga_to_arm_done_read = 1'b1;
    tick;
    fpga_to_arm_done_read = 1'b0;
    chk("done_cleared", fpga_to_arm_done, 1'b0);
    chk("state_idle", leds[2:0], S_IDLE);
    check_slots("cmd");
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_leds"}, leds, 4'b0000);
    chk({tag, "_done"}, fpga_to_arm_done, 1'b0);
    chk({tag, "_rx_ready"}, arm_to_fpga_data_ready, 1'b0);
    chk({tag, "_tx_valid"}, fpga_to_arm_data_valid, 1'b0);
    chk({tag, "_start"}, core_start, '0);
    chk({tag, "_mode"}, core_mode, 1'b0);
    chk({tag, "_err"}, cmd_error, 1'b0);
    chk({tag, "_result"}, fpga_to_arm_data, '0);
    check_slots(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] r1, r2, a5, ones;
    vec_t v;
    resetn = 1'b0;
    arm_to_fpga_cmd = '0; arm_to_fpga_cmd_valid = 1'b0; fpga_to_arm_done_read = 1'b0;
    arm_to_fpga_data_valid = 1'b0; arm_to_fpga_data = '0; fpga_to_arm_data_ready = 1'b0;
    core_done = '0; core_result = '0;
    for (int s = 0; s < NS; s++) m_slot[s] = '0;
    m_result = '0;
    repeat (3) tick;
    check_reset_values("reset");
    resetn = 1'b1;
    tick;

    r1 = rand_wide(); r1[DW-1 -: 16] = 16'h1ad6; r1[15:0] = 16'h1f33;
    r2 = rand_wide(); r2[DW-1 -: 16] = 16'hbdb2; r2[15:0] = 16'h0189;
    a5 = {(DW/8){8'hA5}};
    ones = '1;
    tbl.push_back(mk(4'd5, 4'd0, 4'd0, 0, 1'b0, 0,  1'b0, S_TX,   '0,          '0));
    tbl.push_back(mk(4'd3, 4'd0, 4'd0, 0, 1'b0, 0,  1'b0, S_RX,   a5,          '0));
    tbl.push_back(mk(4'd6, 4'd3, 4'd0, 2, 1'b0, 1,  1'b0, S_RX,   ones,        '0));
    tbl.push_back(mk(4'd6, 4'd7, 4'd0, 0, 1'b0, 0,  1'b1, S_DONE, rand_wide(), '0));
    tbl.push_back(mk(4'd1, 4'd0, 4'd1, 9, 1'b0, 0,  1'b0, S_COMP, '0,          r1));
    tbl.push_back(mk(4'd5, 4'd0, 4'd0, 1, 1'b0, 0,  1'b0, S_TX,   '0,          '0));
    tbl.push_back(mk(4'd0, 4'd0, 4'd0, 4, 1'b1, 0,  1'b0, S_COMP, '0,          r2));
    tbl.push_back(mk(4'd5, 4'd0, 4'd0, 0, 1'b0, 2,  1'b0, S_TX,   '0,          '0));
    tbl.push_back(mk(4'd0, 4'd0, 4'd2, 0, 1'b0, 0,  1'b1, S_DONE, '0,          '0));
    tbl.push_back(mk(4'd7, 4'd0, 4'd0, 0, 1'b0, 0,  1'b1, S_DONE, '0,          '0));
    tbl.push_back(mk(4'd2, 4'd0, 4'd0, 1, 1'b0, 20, 1'b0, S_RX,   rand_wide(), '0));
    tbl.push_back(mk(4'd4, 4'd0, 4'd0, 0, 1'b0, 0,  1'b0, S_RX,   rand_wide(), '0));
    tbl.push_back(mk(4'd15, 4'd0, 4'd0, 0, 1'b0, 0, 1'b1, S_DONE, '0,          '0));
    tbl.push_back(mk(4'd1, 4'd0, 4'd0, 0, 1'b0, 0,  1'b0, S_COMP, '0,          rand_wide()));
    tbl.push_back(mk(4'd5, 4'd0, 4'd0, 0, 1'b0, 0,  1'b0, S_TX,   '0,          '0));
    tbl.push_back(mk(4'd6, 4'd0, 4'd0, 0, 1'b0, 0,  1'b0, S_RX,   rand_wide(), '0));
    foreach (tbl[i]) run_cmd(tbl[i]);

    for (int n = 0; n < 40; n++) begin
      v.op    = ($urandom_range(0, 9) == 9) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      v.slot  = 4'($urandom_range(0, 7));
      v.core  = 4'($urandom_range(0, 3));
      v.delay = $urandom_range(0, 4);
      v.decoy = 1'($urandom_range(0, 1));
      v.hold  = $urandom_range(0, 3);
      v.data  = rand_wide();
      v.res   = rand_wide();
      v.exp_err = m_err(v.op, v.slot, v.core);
      v.exp_st  = m_state(v.op, v.slot, v.core);
      run_cmd(v);
    end

    // Reset in the middle of an RX transfer.
    arm_to_fpga_cmd = {20'd0, 4'd0, 4'd2, 4'd6};
    arm_to_fpga_cmd_valid = 1'b1;
    tick;
    arm_to_fpga_cmd_valid = 1'b0;
    chk("rst_pre_state", leds[2:0], S_RX);
    arm_to_fpga_data = rand_wide();
    arm_to_fpga_data_valid = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    for (int s = 0; s < NS; s++) m_slot[s] = '0;
    m_result = '0;
    check_reset_values("midrst");
    arm_to_fpga_data_valid = 1'b0;
    @(posedge clk);
    #3;
    resetn = 1'b1;
    tick;
    run_cmd(mk(4'd6, 4'd2, 4'd0, 0, 1'b0, 0, 1'b0, S_RX, rand_wide(), '0));
    run_cmd(mk(4'd5, 4'd0, 4'd0, 0, 1'b0, 0, 1'b0, S_TX, '0, '0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rsa_host_if.md
# rsa_host_if

Parametrised host-interface controller between the ARM command/data channels and a bank of Montgomery/RSA cores. It decodes 32-bit commands, loads operands into a configurable number of DATA_W-bit slots, and starts one selected core in exponentiation or Montgomery-multiply mode. It latches that core's result and returns it over the outbound data channel, closing every command with a done/done_read handshake. It generalises the fixed two-core, fixed-slot wrapper protocol with slot addressing, core selection and error reporting.

## Interface
- DATA_W, 1024: operand/result width.
- NUM_SLOTS, 4: operand slots, 2..16.
- NUM_CORES, 2: attached cores, 1..16.
- clk  in  1  single clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- arm_to_fpga_cmd  in  32  command word.
- arm_to_fpga_cmd_valid  in  1  command strobe.
- fpga_to_arm_done  out  1  command complete; held until done_read.
- fpga_to_arm_done_read  in  1  host acknowledges done.
- arm_to_fpga_data_valid / arm_to_fpga_data_ready  in / out  1 / 1  inbound handshake.
- arm_to_fpga_data  in  DATA_W  inbound operand.
- fpga_to_arm_data_valid / fpga_to_arm_data_ready  out / in  1 / 1  outbound handshake.
- fpga_to_arm_data  out  DATA_W  result register.
- core_start  out  NUM_CORES  one-hot, one-cycle start pulse.
- core_mode  out  1  0 = exponentiation, 1 = Montgomery multiply; stable while computing.
- core_done  in  NUM_CORES  per-core completion pulse.
- core_result  in  NUM_CORES*DATA_W  per-core results, core k at [k*DATA_W +: DATA_W].
- slot_data  out  NUM_SLOTS*DATA_W  slot contents to the cores.
- cmd_error  out  1  last command was invalid; cleared on next accepted command.
- leds  out  4  {cmd_error, state[2:0]}.

## Operation
- Command fields: op = cmd[3:0], slot = cmd[7:4], core = cmd[11:8]. cmd[31:12] is ignored.
- Op 0 COMPUTE_EXP and op 1 COMPUTE_MONT go to COMPUTE with core_mode = op[0].
- Ops 2, 3 and 4 (READ_MOD, READ_RSQ, READ_EXP) go to RX and write slots 0, 1 and 2 respectively.
- Op 5 WRITE goes to TX.
- Op 6 READ_SLOT goes to RX and writes slot cmd[7:4].
- Error path: any other op, slot >= NUM_SLOTS on op 6, or core >= NUM_CORES on op 0/1 goes straight to DONE with cmd_error = 1. No slot or core is touched.
- States: IDLE, RX, COMPUTE, TX, DONE (3-bit encoding 0..4).
  - IDLE: a command is accepted on an edge with cmd_valid = 1. While not IDLE, cmd_valid is ignored.
  - RX: arm_to_fpga_data_ready = 1. On an edge with valid & ready, the target slot is written and the state moves to DONE.
  - COMPUTE: core_start[core] pulses in the first COMPUTE cycle only. On core_done[core], core_result slice core is latched into the result register and the state moves to DONE. core_done from non-selected cores is ignored.
  - TX: fpga_to_arm_data_valid = 1 and the result register is driven on fpga_to_arm_data. On an edge with valid & ready, the state moves to DONE.
  - DONE: fpga_to_arm_done = 1. On done_read, the state returns to IDLE.
- The result register persists across commands. WRITE with no prior compute returns 0.
- No width conversion: slots and the result are exactly DATA_W, and operands pass through unmodified.

## Timing
- Reset values: state IDLE, all slots 0, result 0, cmd_error 0, every handshake output 0, core_start 0, core_mode 0, leds 4'b0000.
- A command accepted at edge n is in its target state from cycle n+1.
- core_start is high during cycle n+1 only.
- The minimum RX or TX transfer is one cycle. The earliest done is at cycle n+2.
- A command with an error raises done at cycle n+1.
- done_read sampled at edge m gives IDLE at m+1; a new command is accepted from edge m+1.
- A core_done arriving in the same cycle as core_start is accepted.
- Reset asserted mid-operation: immediate return to the reset state and slots cleared. Any pending core computation is abandoned; the cores reset on the same resetn.

## Structure
- Package rsa_host_pkg: opcode constants OP_COMPUTE_EXP..OP_READ_SLOT, state encoding, field bit positions.
- Sub-module rsa_slot_bank(DATA_W, NUM_SLOTS): write enable, index, data; flat read-out bus; asynchronous-reset clear.
- The top holds the FSM, the result register and the decode.

## Test plan
- Op 3 then 0x…A5 payload -> slot 1 = 0x…A5, done once, cleared by done_read; other slots unchanged.
- Op 6 with slot = 3, data all-ones -> slot 3 = all-ones. Op 6 with slot = 7 (NUM_SLOTS = 4) -> done at n+1, cmd_error = 1, no slot written.
- Op 1, core = 1; model core 1 returns 0x1ad6…1f33 after 10 cycles -> core_start = 2'b10 for one cycle, core_mode = 1. A following op 5 returns 0x1ad6…1f33.
- Op 0, core = 0; core 1 pulses done first, then core 0 returns 0xbdb2…0189 -> the core 1 pulse is ignored and op 5 returns 0xbdb2…0189.
- cmd_valid during COMPUTE -> ignored; done_read held low for 20 cycles -> done stays high and the state holds at DONE.
- resetn low in the middle of RX -> all outputs at reset values and slots 0; the next command is accepted normally.
